// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester bridge.
// Contents: bridge FSM state encoding, default bus widths, response status codes.
package apb_pkg;

  localparam int unsigned APB_ADDR_W_DEF = 32;
  localparam int unsigned APB_DATA_W_DEF = 32;

  // Bridge FSM states; 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10,
    StResp   = 2'b11
  } apb_state_e;

  // Response status reported on rsp_err.
  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state timer for the APB ACCESS phase.
// Ports:
//   apb_pclk, apb_prstn : clock, async active-low reset
//   clear               : zero the counter (used when entering ACCESS)
//   inc                 : count one ACCESS cycle with pready low
//   expired             : this counted cycle is the TIMEOUT-th one; 0 when TIMEOUT == 0
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic apb_pclk,
  input  logic apb_prstn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (TIMEOUT != 0)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fires in the cycle whose increment reaches TIMEOUT, so the bridge leaves
  // ACCESS after exactly TIMEOUT low-pready cycles.
  assign expired = (TIMEOUT != 0) && inc && (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == LIMIT);

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester bridge: valid/ready request port in, APB SETUP/ACCESS out,
// read data and error status back on a valid/ready response port.
// Ports:
//   apb_pclk, apb_prstn                     : clock, async active-low reset
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err   : response channel
//   apb_psel/apb_penable/apb_pwrite/apb_paddr/apb_pwdata : APB requester outputs
//   apb_prdata/apb_pready/apb_pslverr       : APB completer inputs
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W_DEF,
  parameter int unsigned DATA_W  = APB_DATA_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              apb_pclk,
  input  logic              apb_prstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr
);

  apb_state_e        state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tmr_clear, tmr_inc, tmr_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .apb_pclk  (apb_pclk),
    .apb_prstn (apb_prstn),
    .clear     (tmr_clear),
    .inc       (tmr_inc),
    .expired   (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmr_clear = 1'b0;
    tmr_inc   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d  = StSetup;
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        tmr_clear = 1'b1;
      end
      StAccess: begin
        // pready takes priority over a coincident timeout.
        if (apb_pready) begin
          state_d = StResp;
          err_d   = apb_pslverr;
          rdata_d = (!pwrite_q && !apb_pslverr) ? apb_prdata : '0;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_expired) begin
            state_d = StResp;
            err_d   = RSP_ERR;
            rdata_d = '0;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      state_q  <= StIdle;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= RSP_OK;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Control outputs decode straight from state so reset clears them at once.
  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign apb_psel    = (state_q == StSetup) || (state_q == StAccess);
  assign apb_penable = (state_q == StAccess);
  assign apb_pwrite  = pwrite_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT = 4).
module tb_apb_master_bridge;

  logic        apb_pclk = 1'b0;
  logic        apb_prstn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
  logic        apb_pready, apb_pslverr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 apb_pclk = ~apb_pclk;

  apb_master_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .apb_pclk    (apb_pclk),
    .apb_prstn   (apb_prstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_paddr   (apb_paddr),
    .apb_pwdata  (apb_pwdata),
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .apb_pslverr (apb_pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge apb_pclk);
    #1;
  endtask

  task automatic ctl(input string tag, input logic psel, input logic pen, input logic rv);
    chk({tag, ".psel"}, {31'd0, apb_psel}, {31'd0, psel});
    chk({tag, ".penable"}, {31'd0, apb_penable}, {31'd0, pen});
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, rv});
  endtask

  task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    apb_prstn   = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    apb_prdata  = '0;
    apb_pready  = 1'b1;
    apb_pslverr = 1'b0;

    // Reset state
    #12;
    ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.paddr", apb_paddr, 32'd0);
    chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    apb_prstn = 1'b1;
    tick();

    // Zero-wait write
    request(1'b1, 32'h44, 32'h0010_2002);
    tick();
    req_valid = 1'b0;
    ctl("w0.setup", 1'b1, 1'b0, 1'b0);
    chk("w0.req_ready", {31'd0, req_ready}, 32'd0);
    chk("w0.paddr", apb_paddr, 32'h44);
    chk("w0.pwrite", {31'd0, apb_pwrite}, 32'd1);
    chk("w0.pwdata_s", apb_pwdata, 32'h0010_2002);
    tick();
    ctl("w0.access", 1'b1, 1'b1, 1'b0);
    chk("w0.pwdata_a", apb_pwdata, 32'h0010_2002);
    tick();
    ctl("w0.resp", 1'b0, 1'b0, 1'b1);
    chk("w0.rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("w0.rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w0.done", {31'd0, req_ready}, 32'd1);

    // Read with 3 wait states
    request(1'b0, 32'h48, 32'h0);
    apb_pready = 1'b0;
    apb_prdata = 32'hA5A5_0001;
    tick();
    req_valid = 1'b0;
    ctl("r3.setup", 1'b1, 1'b0, 1'b0);
    tick();
    ctl("r3.acc1", 1'b1, 1'b1, 1'b0);
    tick();
    ctl("r3.acc2", 1'b1, 1'b1, 1'b0);
    tick();
    ctl("r3.acc3", 1'b1, 1'b1, 1'b0);
    tick();
    ctl("r3.acc4", 1'b1, 1'b1, 1'b0);
    apb_pready = 1'b1;
    tick();
    ctl("r3.resp", 1'b0, 1'b0, 1'b1);
    chk("r3.rdata", rsp_rdata, 32'hA5A5_0001);
    chk("r3.err", {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Slave error on read
    request(1'b0, 32'h4C, 32'h0);
    apb_prdata  = 32'h0000_DEAD;
    apb_pslverr = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    ctl("se.access", 1'b1, 1'b1, 1'b0);
    tick();
    apb_pslverr = 1'b0;
    ctl("se.resp", 1'b0, 1'b0, 1'b1);
    chk("se.err", {31'd0, rsp_err}, 32'd1);
    chk("se.rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Timeout: pready stuck low
    request(1'b0, 32'h50, 32'h0);
    apb_pready = 1'b0;
    apb_prdata = 32'h1111_2222;
    tick();
    req_valid = 1'b0;
    ctl("to.setup", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      ctl($sformatf("to.acc%0d", i + 1), 1'b1, 1'b1, 1'b0);
    end
    tick();
    ctl("to.resp", 1'b0, 1'b0, 1'b1);
    chk("to.err", {31'd0, rsp_err}, 32'd1);
    chk("to.rdata", rsp_rdata, 32'd0);
    apb_pready = 1'b1;
    rsp_ready  = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Normal transfer after timeout
    request(1'b1, 32'h54, 32'h0BAD_F00D);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    ctl("ta.resp", 1'b0, 1'b0, 1'b1);
    chk("ta.err", {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Back-pressure and back-to-back
    request(1'b0, 32'h58, 32'h0);
    apb_prdata = 32'h1234_5678;
    tick();
    tick();
    tick();
    ctl("bp.resp", 1'b0, 1'b0, 1'b1);
    request(1'b1, 32'h5C, 32'hCAFE_F00D);
    apb_prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp.hold%0d.req_ready", i), {31'd0, req_ready}, 32'd0);
      chk($sformatf("bp.hold%0d.rdata", i), rsp_rdata, 32'h1234_5678);
      ctl($sformatf("bp.hold%0d", i), 1'b0, 1'b0, 1'b1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp.idle.req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp.idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    ctl("bp.b2b.setup", 1'b1, 1'b0, 1'b0);
    chk("bp.b2b.paddr", apb_paddr, 32'h5C);
    chk("bp.b2b.pwdata", apb_pwdata, 32'hCAFE_F00D);
    tick();
    tick();
    ctl("bp.b2b.resp", 1'b0, 1'b0, 1'b1);
    chk("bp.b2b.rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset mid-ACCESS
    request(1'b0, 32'h60, 32'h0);
    apb_pready = 1'b0;
    apb_prdata = 32'h7777_7777;
    tick();
    req_valid = 1'b0;
    tick();
    ctl("rm.access", 1'b1, 1'b1, 1'b0);
    #2;
    apb_prstn = 1'b0;
    #1;
    ctl("rm.inreset", 1'b0, 1'b0, 1'b0);
    chk("rm.inreset.req_ready", {31'd0, req_ready}, 32'd1);
    #10;
    apb_prstn  = 1'b1;
    apb_pready = 1'b1;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ctl($sformatf("rm.after%0d", i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("rm.after%0d.req_ready", i), {31'd0, req_ready}, 32'd1);
    end
    rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
